// File: rtl/clock_display_scan.sv
// clock_display_scan
//
// Display stage for the clock/timer counter. Converts the binary hour, minute
// and second counts to BCD and drives a 6-digit, time-multiplexed,
// common-anode 7-segment display. One digit is lit at a time. In set mode the
// selected field blinks. In timer mode the decimal point on digit 0 is lit.
//
// Digit map: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens,
//            4 = hour ones, 5 = hour tens.
//
// Parameters:
//   SCAN_DIV   i_clk cycles each digit is held (>= 2)
//   BLINK_DIV  i_clk cycles per blink half-period (>= 2)
//
// Ports:
//   i_clk      system clock
//   i_reset    asynchronous active-high reset
//   i_count_h  hour count, binary 0..63
//   i_count_m  minute count, binary 0..63
//   i_count_s  second count, binary 0..63
//   i_mode     1 = clock mode, 0 = timer mode
//   i_set      set mode active
//   i_hour     hour field selected for editing
//   i_min      minute field selected for editing
//   i_sec      second field selected for editing
//   o_an       digit enables, active-low, bit k = digit k
//   o_seg      segments {g,f,e,d,c,b,a}, active-low
//   o_dp       decimal point, active-low
module clock_display_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_count_h,
  input  logic [5:0] i_count_m,
  input  logic [5:0] i_count_s,
  input  logic       i_mode,
  input  logic       i_set,
  input  logic       i_hour,
  input  logic       i_min,
  input  logic       i_sec,
  output logic [5:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  localparam int unsigned ScanW  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);

  // Field codes, derived from the digit index as index >> 1.
  localparam logic [1:0] FieldSec  = 2'd0;
  localparam logic [1:0] FieldMin  = 2'd1;
  localparam logic [1:0] FieldHour = 2'd2;
  localparam logic [1:0] FieldNone = 2'd3;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [5:0] AnOff    = 6'b111111;

  // Binary 0..63 to {tens, ones}. A compare chain keeps this to a few small
  // comparators instead of a general divider.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd60) begin
      tens = 4'd6;
      ones = 4'(v - 6'd60);
    end else if (v >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0;
      ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  // Active-low gfedcba patterns.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SegBlank;
    endcase
    return code;
  endfunction

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]        digit_q, digit_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [5:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic              scan_wrap;
  logic              blink_wrap;

  // Scan prescaler and digit index.
  always_comb begin
    scan_wrap  = (scan_cnt_q == ScanMax);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (scan_wrap) begin
      digit_d = (digit_q == 3'd5) ? 3'd0 : digit_q + 3'd1;
    end
  end

  // Free-running blink timebase, independent of i_set so the phase never
  // depends on when set mode was entered.
  always_comb begin
    blink_wrap    = (blink_cnt_q == BlinkMax);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
  end

  // Output decode from the current index and live inputs.
  logic [1:0] cur_field;
  logic [1:0] sel_field;
  logic [5:0] cur_value;
  logic [7:0] cur_bcd;
  logic [3:0] cur_digit;
  logic       blank;

  always_comb begin
    cur_field = digit_q[2:1];

    unique case (cur_field)
      FieldSec:  cur_value = i_count_s;
      FieldMin:  cur_value = i_count_m;
      FieldHour: cur_value = i_count_h;
      default:   cur_value = 6'd0;
    endcase

    cur_bcd   = to_bcd(cur_value);
    cur_digit = digit_q[0] ? cur_bcd[7:4] : cur_bcd[3:0];

    // Hour wins over minute, minute over second.
    if (i_hour) begin
      sel_field = FieldHour;
    end else if (i_min) begin
      sel_field = FieldMin;
    end else if (i_sec) begin
      sel_field = FieldSec;
    end else begin
      sel_field = FieldNone;
    end

    blank = i_set && blink_phase_q && (sel_field == cur_field);

    an_d  = AnOff;
    seg_d = SegBlank;
    dp_d  = 1'b1;
    if (!blank) begin
      an_d[digit_q] = 1'b0;
      seg_d         = seg_code(cur_digit);
      // Separators after hours and minutes; digit 0 marks timer mode.
      dp_d = !((digit_q == 3'd2) || (digit_q == 3'd4) || ((digit_q == 3'd0) && !i_mode));
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      scan_cnt_q    <= '0;
      digit_q       <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= AnOff;
      seg_q         <= SegBlank;
      dp_q          <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;
  assign o_dp  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
module tb_clock_display_scan;

  localparam int SD = 4;
  localparam int BD = 8;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic [5:0] i_count_h, i_count_m, i_count_s;
  logic       i_mode, i_set, i_hour, i_min, i_sec;
  logic [5:0] o_an;
  logic [6:0] o_seg;
  logic       o_dp;

  clock_display_scan #(
    .SCAN_DIV (SD),
    .BLINK_DIV(BD)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_count_h(i_count_h),
    .i_count_m(i_count_m),
    .i_count_s(i_count_s),
    .i_mode   (i_mode),
    .i_set    (i_set),
    .i_hour   (i_hour),
    .i_min    (i_min),
    .i_sec    (i_sec),
    .o_an     (o_an),
    .o_seg    (o_seg),
    .o_dp     (o_dp)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   n = 0;        // rising edges since the last reset release
  bit   run = 1'b0;

  logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    end
  endtask

  // Reference: the output presented on edge k+1 reflects k elapsed edges.
  function automatic exp_t model(input int k);
    exp_t e;
    int d, ph, field, v, sel, dig;
    bit blank;
    d     = (k / SD) % 6;
    ph    = (k / BD) % 2;
    field = d / 2;
    v     = (field == 0) ? int'(i_count_s) : (field == 1) ? int'(i_count_m) : int'(i_count_h);
    dig   = (d % 2 == 1) ? v / 10 : v % 10;
    sel   = i_hour ? 2 : i_min ? 1 : i_sec ? 0 : -1;
    blank = i_set && (ph == 1) && (sel == field);
    if (blank) begin
      e.an  = 6'b111111;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
    end else begin
      e.an  = ~(6'(1) << d);
      e.seg = seg_tab[dig];
      e.dp  = !((d == 2) || (d == 4) || (d == 0 && !i_mode));
    end
    return e;
  endfunction

  // Predictor: inputs only change on falling edges, so they are stable here.
  always @(posedge i_clk) begin
    if (run && !i_reset) begin
      exp_q.push_back(model(n));
      n++;
    end
  end

  // Monitor: the DUT presents a new output every cycle.
  always @(posedge i_clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("an", int'(o_an), int'(e.an));
      chk("seg", int'(o_seg), int'(e.seg));
      chk("dp", int'(o_dp), int'(e.dp));
    end
  end

  task automatic check_blank(input string name);
    chk({name, "_an"}, int'(o_an), 'h3f);
    chk({name, "_seg"}, int'(o_seg), 'h7f);
    chk({name, "_dp"}, int'(o_dp), 1);
  endtask

  initial begin
    i_count_h = 6'd12;
    i_count_m = 6'd34;
    i_count_s = 6'd56;
    i_mode = 1'b1;
    i_set  = 1'b0;
    i_hour = 1'b0;
    i_min  = 1'b0;
    i_sec  = 1'b0;

    repeat (3) @(negedge i_clk);
    check_blank("reset");
    n = 0;
    run = 1'b1;
    i_reset = 1'b0;

    // Full frames with the basic pattern, then decimal-point and boundaries.
    repeat (30) @(negedge i_clk);
    i_mode = 1'b0;
    repeat (24) @(negedge i_clk);
    i_count_h = 6'd0;
    i_count_s = 6'd63;
    repeat (24) @(negedge i_clk);
    i_count_s = 6'd59;
    repeat (24) @(negedge i_clk);

    // Blinking: minute field, then hour takes priority.
    i_set = 1'b1;
    i_min = 1'b1;
    repeat (48) @(negedge i_clk);
    i_hour = 1'b1;
    repeat (48) @(negedge i_clk);
    i_sec = 1'b1;
    i_hour = 1'b0;
    i_min = 1'b0;
    repeat (48) @(negedge i_clk);
    i_set = 1'b0;
    i_sec = 1'b0;

    // Live update while digit 0 is showing.
    i_count_s = 6'd8;
    while (((n - 1) / SD) % 6 != 0) @(negedge i_clk);
    @(negedge i_clk);
    i_count_s = 6'd9;
    repeat (24) @(negedge i_clk);

    // Asynchronous reset while digit 3 is on the display.
    while (((n - 1) / SD) % 6 != 3) @(negedge i_clk);
    chk("pre_reset_an", int'(o_an), 'h37);
    #2;
    i_reset = 1'b1;
    #1;
    check_blank("async_reset");
    repeat (2) @(negedge i_clk);
    check_blank("held_reset");
    exp_q.delete();
    n = 0;
    i_reset = 1'b0;
    @(posedge i_clk);
    #2;
    chk("first_after_reset_an", int'(o_an), 'h3e);

    // Randomized inputs.
    repeat (800) begin
      @(negedge i_clk);
      if ($urandom_range(0, 3) == 0) begin
        i_count_h = 6'($urandom_range(0, 63));
        i_count_m = 6'($urandom_range(0, 63));
        i_count_s = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 15) == 0) begin
        i_mode = 1'($urandom);
        i_set  = 1'($urandom);
        i_hour = 1'($urandom);
        i_min  = 1'($urandom);
        i_sec  = 1'($urandom);
      end
    end

    repeat (3) @(negedge i_clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
Downstream display stage for the digital clock/timer counter. Takes the binary hour/minute/second counts (6 bits each) and drives a 6-digit, time-multiplexed, common-anode 7-segment display.
- Converts each field to two BCD digits.
- Scans one digit at a time.
- Blinks the field being edited in set mode.
- Marks timer mode on the decimal points.

Parameters:
SCAN_DIV, 50000, i_clk cycles each digit is held before advancing to the next digit (>=2)
BLINK_DIV, 25000000, i_clk cycles per blink half-period (>=2)

Ports:
i_clk  input  1  system clock, single clock domain
i_reset  input  1  asynchronous active-high reset
i_count_h  input  6  hour count, binary, 0..63
i_count_m  input  6  minute count, binary, 0..63
i_count_s  input  6  second count, binary, 0..63
i_mode  input  1  1 = clock mode, 0 = timer mode
i_set  input  1  set mode active
i_hour  input  1  hour field selected for editing
i_min  input  1  minute field selected for editing
i_sec  input  1  second field selected for editing
o_an  output  6  digit enables, active-low; bit k = digit k
o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low
o_dp  output  1  decimal point, active-low

Behaviour:
Clock and reset:
- One clock, i_clk. i_reset is asynchronous and active-high.
- While i_reset=1, all registers are cleared: scan prescaler=0, digit index=0, blink counter=0, blink_phase=0.
- Outputs during reset: o_an=6'b111111 (all digits off), o_seg=7'b1111111, o_dp=1.
- Reset asserted mid-scan blanks the display immediately (asynchronously).

Digit map:
- Digit 0 = sec ones, digit 1 = sec tens.
- Digit 2 = min ones, digit 3 = min tens.
- Digit 4 = hour ones, digit 5 = hour tens.

Scan:
- The prescaler counts 0..SCAN_DIV-1, then wraps to 0.
- On the cycle the prescaler equals SCAN_DIV-1, the digit index advances: 0->1->...->5->0.
- Each digit is held for exactly SCAN_DIV cycles. One frame = 6*SCAN_DIV cycles.

Registered outputs:
- o_an, o_seg and o_dp are registered from the current digit index and the current input values.
- Latency is 1 cycle: the first rising edge after reset release presents digit 0.
- The outputs follow each index change 1 cycle later.
- Inputs are not snapshotted per frame; a field change is visible on the next cycle its digit is driven.

o_an:
- Exactly one bit is low, bit[index]. All other bits are high.
- Exception: a blanked digit drives all bits high.

BCD conversion:
- tens = v/10, ones = v%10, for 0<=v<=63.
- Out-of-range transients are shown literally: 60..63 display as "60".."63".
- No leading-zero suppression: 0 displays as "00".

Segment codes (active-low gfedcba):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Blink:
- A free-running counter counts 0..BLINK_DIV-1 and wraps. At wrap, blink_phase toggles.
- When i_set=1 and blink_phase=1, both digits of the selected field are blanked: o_an all high, o_seg=1111111, o_dp=1.
- Field priority when several selects are high: i_hour > i_min > i_sec.
- No select high, or i_set=0: no blanking.
- The blink counter runs regardless of i_set. A blink toggle coinciding with a digit advance is legal; both take effect in the same cycle.

Decimal point:
- o_dp=0 on digits 2 and 4 (h.m.s separators).
- Additionally o_dp=0 on digit 0 when i_mode=0 (timer indicator).
- All other cases o_dp=1.

Test Plan:
1. SCAN_DIV=4, h=12, m=34, s=56, i_set=0, release reset:
   - Edge 1: o_an=111110, o_seg=0000010 ("6").
   - Edge 5: o_an=111101, o_seg=0010010 ("5").
   - Digit 5 shows "1" (1111001) with o_an=011111.
   - Back to digit 0 at edge 25.
2. Decimal points:
   - i_mode=1: o_dp=0 only while o_an=111011 or 101111.
   - Set i_mode=0: o_dp=0 also while o_an=111110.
3. Boundary values:
   - h=0: digits 4 and 5 show 1000000.
   - s=63: digit 1 shows "6" (0000010), digit 0 shows "3" (0110000).
   - s=59: "9" (0010000) then "5".
4. Blinking, BLINK_DIV=8, i_set=1, i_min=1:
   - During cycles with blink_phase=1, digits 2/3 drive o_an=111111 and o_seg=1111111.
   - Other digits unaffected.
   - Raise i_hour too: digits 4/5 blank instead, digits 2/3 visible.
5. Reset mid-scan while digit 3 is active: assert i_reset asynchronously between edges.
   - o_an=111111 immediately.
   - After release, digit 0 is presented on the first edge.
6. Live update: change i_count_s from 8 to 9 while digit 0 is active.
   - o_seg goes 0000000 -> 0010000 one cycle later.
   - o_an unchanged.
